bus_frame_receiver: RTL
=======================

Name: bus_frame_receiver

Overview:
- Per-node receive stage that sits directly downstream of the shared serial bus driven by the 16-node transmit/arbitration block (the `bus_show` line).
- Detects a frame start, deserializes the address, 64-bit payload and CRC-4, and checks the CRC.
- Filters frames on its own node address or the broadcast address.
- Presents accepted payloads with a one-cycle valid strobe and keeps saturating statistics counters.
- One instance per node.

Parameters:
- NODE_ADDR, 4'd1: this node's address; frames carrying it are accepted.
- BCAST_ADDR, 4'hF: broadcast address; frames carrying it are accepted by every node.
- ADDR_W, 4: receiver-address field width.
- DATA_W, 64: payload width.
- CRC_W, 4: CRC field width; polynomial x^4+x+1, init 0.
- CNT_W, 16: statistics counter width.

Ports:
- clock  in  1  system clock; everything samples on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- bus_in  in  1  serial bus line, one bit per clock; idles at 0.
- rx_data  out  DATA_W  last accepted payload; held until the next accept.
- rx_addr  out  ADDR_W  address field of the last accepted frame.
- rx_valid  out  1  one-cycle pulse per accepted frame.
- crc_err  out  1  one-cycle pulse per frame failing CRC, regardless of address.
- busy  out  1  high while a frame is being received (any state except IDLE).
- frames_ok  out  CNT_W  count of accepted frames, saturating.
- frames_bad  out  CNT_W  count of CRC failures, saturating.

Behaviour:
- Reset: asynchronous assert, synchronous release. Everything clears to zero: all outputs, state = IDLE, CRC register and bit counter. A partial frame in flight is discarded, with no strobe.
- Frame format on bus_in, MSB first:
  - start bit = 1
  - ADDR_W address bits
  - DATA_W data bits
  - CRC_W CRC bits
  - Total 73 cycles for default widths.
- FSM transitions:
  - IDLE → ADDR when bus_in = 1.
  - ADDR: shift ADDR_W bits → DATA.
  - DATA: shift DATA_W bits → CRC.
  - CRC: shift CRC_W bits → IDLE.
- A single bit counter is loaded with (field width − 1) on each field entry and counts down to 0.
- CRC generator:
  - Serial LFSR over the address and data bits only: fb = crc[3] ^ bit; crc <= {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000).
  - Cleared on the start bit.
- Received CRC bits are shifted into a separate compare register.
- Decision, made on the cycle the last CRC bit is sampled, registered, and visible on the next cycle (1-cycle latency after the last bit):
  - Mismatch: crc_err = 1 and frames_bad increments. No rx_valid, and rx_data is unchanged.
  - Match and (addr == NODE_ADDR or addr == BCAST_ADDR): rx_valid = 1, rx_data/rx_addr load, frames_ok increments.
  - Match and other address: silently dropped, no strobe.
- Back-to-back frames: the FSM is in IDLE in the decision-output cycle. A start bit on that cycle is accepted, so zero idle gap is supported. rx_valid/crc_err of the old frame and the new start coexist.
- Counters saturate at all-ones; no wrap.
- A start bit is recognized only in IDLE. A 1 inside a field is data.
- No timeout: the bus is assumed to deliver complete frames. The reset_n mid-frame rule above applies.

Decomposition:
- Shared package `bus_frame_pkg`:
  - ADDR_W, DATA_W, CRC_W, CRC_POLY = 4'b0011, BCAST_ADDR
  - FSM state enum {IDLE, ADDR, DATA, CRC}
  - Frame-length constant
  - The transmitter uses the same package.
- One natural sub-module: `crc4_serial`.
  - Inputs: clear, enable, bit.
  - Output: 4-bit remainder.
  - Shared with the transmit side so both ends compute identical CRCs.

Test Plan:
- Reset values: assert reset_n = 0 mid-run → all outputs 0 and busy = 0 immediately. Release, send a valid frame → normal accept (no residue).
- Basic accept: NODE_ADDR = 1; frame addr = 1, data = 64'h1, crc = 4'h6 → rx_valid pulses exactly 1 cycle, 1 cycle after the last CRC bit; rx_data = 64'h1; rx_addr = 1; frames_ok = 1.
- CRC error: same frame with crc = 4'h7 → crc_err pulses once, rx_valid stays 0, frames_bad = 1, rx_data keeps its previous value.
- Address filtering:
  - Frame addr = 2 with correct CRC → no strobe, counters unchanged.
  - Frame addr = 4'hF with correct CRC → rx_valid = 1, rx_addr = F.
- Back-to-back: two valid frames with zero gap (second start bit on the decision cycle of the first) → two rx_valid pulses exactly 73 cycles apart, both payloads correct.
- Saturation and abort:
  - Force frames_ok to 16'hFFFE, send 3 valid frames → frames_ok stays at 16'hFFFF.
  - Pulse reset_n low at bit 30 of a frame → no strobe; the next full frame is accepted.

Source files
------------

// File: rtl/bus_frame_pkg.sv
// Shared definitions for the serial bus frame format (used by transmit and receive sides).
package bus_frame_pkg;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned CRC_W     = 4;
    localparam int unsigned FRAME_LEN = 1 + ADDR_W + DATA_W + CRC_W;

    // Bit counter only has to hold the widest field minus one.
    localparam int unsigned BIT_CNT_W = $clog2(DATA_W);

    localparam logic [CRC_W-1:0]  CRC_POLY   = 4'b0011;
    localparam logic [ADDR_W-1:0] BCAST_ADDR = 4'hF;

    // Receive FSM states.
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StCrc  = 2'd3;

    // One step of the serial CRC-4 (x^4+x+1), MSB-first.
    function automatic logic [CRC_W-1:0] crc4_next(input logic [CRC_W-1:0] crc,
                                                   input logic            b);
        logic fb;
        fb = crc[CRC_W-1] ^ b;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_W{1'b0}});
    endfunction

endpackage

// File: rtl/bus_frame_receiver_crc4_serial.sv
// Serial CRC-4 generator; identical instance sits on the transmit side.
module crc4_serial
    import bus_frame_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] crc_d, crc_q;

    // Clear has priority so a start bit always restarts the remainder.
    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = crc4_next(crc_q, bit_i);
        end
    end

    // Remainder register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/bus_frame_receiver.sv
// Per-node serial frame receiver: deserialize, CRC check, address filter, statistics.
module bus_frame_receiver
    import bus_frame_pkg::*;
#(
    parameter logic [3:0]  NODE_ADDR  = 4'd1,
    parameter logic [3:0]  BCAST_ADDR = bus_frame_pkg::BCAST_ADDR,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              bus_in,
    output logic [DATA_W-1:0] rx_data,
    output logic [ADDR_W-1:0] rx_addr,
    output logic              rx_valid,
    output logic              crc_err,
    output logic              busy,
    output logic [CNT_W-1:0]  frames_ok,
    output logic [CNT_W-1:0]  frames_bad
);

    logic [1:0]           state_d, state_q;
    logic [BIT_CNT_W-1:0] bit_cnt_d, bit_cnt_q;
    logic [ADDR_W-1:0]    addr_sr_d, addr_sr_q;
    logic [DATA_W-1:0]    data_sr_d, data_sr_q;
    logic [CRC_W-1:0]     crc_rx_d, crc_rx_q;
    logic [DATA_W-1:0]    rx_data_d, rx_data_q;
    logic [ADDR_W-1:0]    rx_addr_d, rx_addr_q;
    logic                 rx_valid_d, rx_valid_q;
    logic                 crc_err_d, crc_err_q;
    logic [CNT_W-1:0]     frames_ok_d, frames_ok_q;
    logic [CNT_W-1:0]     frames_bad_d, frames_bad_q;

    logic                 crc_clear, crc_en, decide;
    logic [CRC_W-1:0]     crc_calc;
    logic [CRC_W-1:0]     crc_rx_full;
    logic                 addr_hit;

    crc4_serial u_crc (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .clear_i (crc_clear),
        .en_i    (crc_en),
        .bit_i   (bus_in),
        .crc_o   (crc_calc)
    );

    // Received CRC including the bit being sampled this cycle.
    assign crc_rx_full = {crc_rx_q[CRC_W-2:0], bus_in};
    assign addr_hit    = (addr_sr_q == NODE_ADDR) || (addr_sr_q == BCAST_ADDR);

    // Frame FSM and field shift registers.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_sr_d = addr_sr_q;
        data_sr_d = data_sr_q;
        crc_rx_d  = crc_rx_q;
        crc_clear = 1'b0;
        crc_en    = 1'b0;
        decide    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus_in) begin
                    state_d   = StAddr;
                    bit_cnt_d = BIT_CNT_W'(ADDR_W - 1);
                    crc_clear = 1'b1;
                end
            end
            StAddr: begin
                addr_sr_d = {addr_sr_q[ADDR_W-2:0], bus_in};
                crc_en    = 1'b1;
                if (bit_cnt_q == '0) begin
                    state_d   = StData;
                    bit_cnt_d = BIT_CNT_W'(DATA_W - 1);
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            StData: begin
                data_sr_d = {data_sr_q[DATA_W-2:0], bus_in};
                crc_en    = 1'b1;
                if (bit_cnt_q == '0) begin
                    state_d   = StCrc;
                    bit_cnt_d = BIT_CNT_W'(CRC_W - 1);
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            default: begin
                crc_rx_d = crc_rx_full;
                if (bit_cnt_q == '0) begin
                    state_d = StIdle;
                    decide  = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
        endcase
    end

    // Accept/reject decision on the last CRC bit; strobes are single-cycle.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_addr_d    = rx_addr_q;
        rx_valid_d   = 1'b0;
        crc_err_d    = 1'b0;
        frames_ok_d  = frames_ok_q;
        frames_bad_d = frames_bad_q;
        if (decide) begin
            if (crc_rx_full != crc_calc) begin
                crc_err_d = 1'b1;
                if (frames_bad_q != '1) frames_bad_d = frames_bad_q + CNT_W'(1);
            end else if (addr_hit) begin
                rx_valid_d = 1'b1;
                rx_data_d  = data_sr_q;
                rx_addr_d  = addr_sr_q;
                if (frames_ok_q != '1) frames_ok_d = frames_ok_q + CNT_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            addr_sr_q    <= '0;
            data_sr_q    <= '0;
            crc_rx_q     <= '0;
            rx_data_q    <= '0;
            rx_addr_q    <= '0;
            rx_valid_q   <= 1'b0;
            crc_err_q    <= 1'b0;
            frames_ok_q  <= '0;
            frames_bad_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_sr_q    <= addr_sr_d;
            data_sr_q    <= data_sr_d;
            crc_rx_q     <= crc_rx_d;
            rx_data_q    <= rx_data_d;
            rx_addr_q    <= rx_addr_d;
            rx_valid_q   <= rx_valid_d;
            crc_err_q    <= crc_err_d;
            frames_ok_q  <= frames_ok_d;
            frames_bad_q <= frames_bad_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_addr    = rx_addr_q;
    assign rx_valid   = rx_valid_q;
    assign crc_err    = crc_err_q;
    assign busy       = (state_q != StIdle);
    assign frames_ok  = frames_ok_q;
    assign frames_bad = frames_bad_q;

endmodule
